// File: rtl/antares_memory_responder_pkg.sv
// antares_memory_responder_pkg: FSM encoding, default window bases and the window comparator
package antares_memory_responder_pkg;
  typedef enum logic [1:0] {MRSP_IDLE = 2'd0, MRSP_BUSY = 2'd1, MRSP_DONE = 2'd2} mrsp_state_e;
  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;
  localparam logic [31:0] DMEM_BASE = 32'h8000_0000;
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base, input int aw);
    logic [31:0] mask;
    mask = ~((32'd4 << aw) - 32'd1);
    return ((addr ^ base) & mask) == 32'd0;
  endfunction
endpackage

// File: rtl/antares_byte_ram.sv
// antares_byte_ram: word RAM with per-byte write enables and a one-cycle registered read
module antares_byte_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/antares_memory_responder.sv
// antares_memory_responder: enable/ready/error memory target with wait states and window check
module antares_memory_responder
  import antares_memory_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] port_address,
  input  logic [31:0] port_data_i,
  input  logic [3:0]  port_wr,
  input  logic        port_enable,
  output logic [31:0] port_data_o,
  output logic        port_ready,
  output logic        port_error
);
  mrsp_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, wr_q, wr_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, rdata;
  logic        ready_q, ready_d, error_q, error_d, hit, finish, we;
  logic [ADDR_WIDTH-1:0] raddr;
  assign hit    = in_window(addr_q, BASE_ADDR, ADDR_WIDTH);
  assign finish = state_q == MRSP_BUSY && port_enable && cnt_q == 4'd0;
  assign we     = finish && hit && |wr_q && !rst;
  // In IDLE the RAM already reads the incoming address so data is ready by DONE entry even with no wait states
  assign raddr  = state_q == MRSP_IDLE ? port_address[ADDR_WIDTH+1:2] : addr_q[ADDR_WIDTH+1:2];
  antares_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk(clk), .we(we), .be(wr_q), .waddr(addr_q[ADDR_WIDTH+1:2]),
    .wdata(wdata_q), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    ready_d = ready_q;
    error_d = error_q;
    case (state_q)
      MRSP_IDLE: if (port_enable) begin
        state_d = MRSP_BUSY;
        cnt_d   = 4'(WAIT_STATES);
        addr_d  = port_address;
        wr_d    = port_wr;
        wdata_d = port_data_i;
      end
      MRSP_BUSY: begin
        state_d = !port_enable ? MRSP_IDLE : finish ? MRSP_DONE : MRSP_BUSY;
        cnt_d   = port_enable && !finish ? cnt_q - 4'd1 : cnt_q;
        ready_d = finish && hit;
        error_d = finish && !hit;
        data_d  = !finish ? data_q : (hit && wr_q == 4'd0) ? rdata : 32'd0;
      end
      MRSP_DONE: if (!port_enable) begin
        state_d = MRSP_IDLE;
        ready_d = 1'b0;
        error_d = 1'b0;
      end
      default: state_d = MRSP_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MRSP_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wr_q    <= 4'd0;
      wdata_q <= 32'd0;
      data_q  <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end
  assign port_data_o = data_q;
  assign port_ready  = ready_q;
  assign port_error  = error_q;
endmodule

// File: tb/tb_antares_memory_responder.sv
// tb_antares_memory_responder: scoreboard bench over three responders (1, 3 and 0 wait states)
module tb_antares_memory_responder;
  logic clk = 1'b0, rst;
  logic [31:0] addr[3], din[3], dout[3];
  logic [3:0]  wr[3];
  logic        en[3], rdy[3], err[3];
  typedef struct {bit err; logic [31:0] data; string name;} exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    antares_memory_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(g == 0 ? 1 : g == 1 ? 3 : 0)) u_dut (
      .clk(clk), .rst(rst), .port_address(addr[g]), .port_data_i(din[g]), .port_wr(wr[g]),
      .port_enable(en[g]), .port_data_o(dout[g]), .port_ready(rdy[g]), .port_error(err[g])
    );
  end
  function automatic int ws_of(input int k);
    return k == 0 ? 1 : k == 1 ? 3 : 0;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin
    bit prev[3] = '{0, 0, 0};
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if ((rdy[k] || err[k]) && !prev[k]) begin
          if (sbq.size() == 0) check($sformatf("unexpected response dut%0d", k), 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            check({e.name, " ready/error"}, {30'd0, rdy[k], err[k]}, e.err ? 32'd1 : 32'd2);
            check({e.name, " data"}, dout[k], e.data);
          end
        end
        prev[k] = rdy[k] || err[k];
      end
    end
  end
  task automatic xfer(input int k, input string name, input logic [31:0] a, input logic [3:0] w,
                      input logic [31:0] d, input bit e, input logic [31:0] x, input int hold = 0);
    int n = 0;
    sbq.push_back('{e, x, name});
    addr[k] = a; wr[k] = w; din[k] = d; en[k] = 1'b1;
    do begin @(negedge clk); n++; end while (!(rdy[k] || err[k]) && n < 40);
    check({name, " latency"}, n, ws_of(k) + 2);
    addr[k] = ~a; din[k] = ~d; wr[k] = ~w;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, " sticky"}, {30'd0, rdy[k], err[k]}, e ? 32'd1 : 32'd2);
    end
    en[k] = 1'b0;
    @(negedge clk);
    check({name, " clear"}, {30'd0, rdy[k], err[k]}, 32'd0);
  endtask
  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin addr[k] = 0; din[k] = 0; wr[k] = 0; en[k] = 0; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset dut%0d", k), {dout[k][29:0], rdy[k], err[k]} | dout[k], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    xfer(0, "w5",      32'h14,        4'hF,    32'hDEAD_BEEF, 0, 32'h0);
    xfer(0, "r5",      32'h14,        4'h0,    32'h0,         0, 32'hDEAD_BEEF);
    xfer(0, "w5b",     32'h14,        4'hF,    32'h1122_3344, 0, 32'h0);
    xfer(0, "wbyte",   32'h16,        4'b0100, 32'hAAAA_AAAA, 0, 32'h0);
    xfer(0, "rbyte",   32'h14,        4'h0,    32'h0,         0, 32'h11AA_3344);
    xfer(0, "w0",      32'h0,         4'hF,    32'h0123_4567, 0, 32'h0);
    xfer(0, "wmiss",   32'h0001_0000, 4'hF,    32'hFFFF_FFFF, 1, 32'h0);
    xfer(0, "rmiss",   32'h0000_1000, 4'h0,    32'h0,         1, 32'h0);
    xfer(0, "r0",      32'h0,         4'h0,    32'h0,         0, 32'h0123_4567);
    xfer(0, "w6",      32'h18,        4'hF,    32'h0,         0, 32'h0);
    xfer(0, "wsticky", 32'h18,        4'b0011, 32'hCAFE_F00D, 0, 32'h0, 4);
    xfer(0, "r6",      32'h18,        4'h0,    32'h0,         0, 32'h0000_F00D);
    sbq.push_back('{0, 32'h11AA_3344, "rst_done"});
    addr[0] = 32'h14; wr[0] = 0; en[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy[0] && n < 40);
    rst = 1'b1;
    @(negedge clk);
    check("rst in DONE", {dout[0][29:0], rdy[0], err[0]} | dout[0], 32'd0);
    rst = 1'b0; en[0] = 1'b0;
    @(negedge clk);
    xfer(1, "w2", 32'h8, 4'hF, 32'h0000_0055, 0, 32'h0);
    addr[1] = 32'h8; wr[1] = 4'hF; din[1] = 32'hFFFF_FFFF; en[1] = 1'b1;
    repeat (2) @(negedge clk);
    en[1] = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); seen |= rdy[1] | err[1]; end
    check("abort no response", {31'd0, seen}, 32'd0);
    xfer(1, "r2 after abort", 32'h8, 4'h0, 32'h0, 0, 32'h0000_0055);
    addr[1] = 32'h8; wr[1] = 4'hF; din[1] = 32'h0000_0BAD; en[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst in BUSY", {dout[1][29:0], rdy[1], err[1]} | dout[1], 32'd0);
    rst = 1'b0; en[1] = 1'b0;
    @(negedge clk);
    xfer(1, "r2 after rst", 32'h8, 4'h0, 32'h0, 0, 32'h0000_0055);
    xfer(2, "w9",     32'h24, 4'hF,    32'h1357_9BDF, 0, 32'h0);
    xfer(2, "r9a",    32'h24, 4'h0,    32'h0,         0, 32'h1357_9BDF);
    xfer(2, "r9b",    32'h24, 4'h0,    32'h0,         0, 32'h1357_9BDF);
    xfer(2, "wlane3", 32'h24, 4'b1000, 32'h7777_7777, 0, 32'h0);
    xfer(2, "r9c",    32'h24, 4'h0,    32'h0,         0, 32'h7757_9BDF);
    repeat (2) @(negedge clk);
    check("scoreboard drained", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
